// File: rtl/axi_req_arb_pkg.sv
// Shared types and width helpers for the AXI request round-robin arbiter.
// Imported by the picker and the arbiter top.
package axi_req_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// scanning with wrap-around.
module axi_rr_pick
  import axi_req_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotate so that bit 0 is the requester at ptr.
  logic [N-1:0] rot;
  assign rot = N'({valid, valid} >> ptr);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + j) % N);
      end
    end
  end

  assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/axi_req_rr_arbiter.sv
// Round-robin arbiter sharing one AXI AW/AR channel between requesters,
// with ID extension, outstanding limit and idle/error status.
module axi_req_rr_arbiter
  import axi_req_arb_pkg::*;
#(
  parameter int NB_REQ          = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 2,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = idx_width(NB_REQ),
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable_i,
  input  logic [NB_REQ-1:0]                      req_valid_i,
  output logic [NB_REQ-1:0]                      req_ready_o,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NB_REQ-1:0][ID_WIDTH-1:0]        req_id_i,
  input  logic [NB_REQ-1:0][7:0]                 req_len_i,
  input  logic [NB_REQ-1:0][USER_WIDTH-1:0]      req_user_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [ADDR_WIDTH-1:0]                  out_addr_o,
  output logic [ID_WIDTH+IDX_W-1:0]              out_id_o,
  output logic [7:0]                             out_len_o,
  output logic [USER_WIDTH-1:0]                  out_user_o,
  input  logic                                   rsp_done_i,
  output logic [CNT_W-1:0]                       outstanding_o,
  output logic                                   idle_o,
  output logic                                   err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  k_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [NB_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              grant;
  logic              hs;
  logic              dec;

  axi_rr_pick #(
    .N  (NB_REQ),
    .IW (IDX_W)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant = !rst && (state_q == IDLE) && enable_i
              && (cnt_q < MAX_CNT) && pick_any;
  assign hs    = (state_q == ISSUE) && out_ready_i;
  assign dec   = rsp_done_i && (cnt_q != '0);

  assign req_ready_o   = grant ? pick_gnt : '0;
  assign out_valid_o   = (state_q == ISSUE);
  assign outstanding_o = cnt_q;
  assign idle_o        = (state_q == IDLE) && (cnt_q == '0);
  assign err_o         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      k_q        <= '0;
      out_addr_o <= '0;
      out_id_o   <= '0;
      out_len_o  <= '0;
      out_user_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q    <= ISSUE;
            k_q        <= pick_idx;
            out_addr_o <= req_addr_i[pick_idx];
            out_id_o   <= {pick_idx, req_id_i[pick_idx]};
            out_len_o  <= req_len_i[pick_idx];
            out_user_o <= req_user_i[pick_idx];
          end
        end
        ISSUE: begin
          if (out_ready_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(wrap_inc(int'(k_q), NB_REQ));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A completion arriving with nothing in flight is a protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs && !dec)
        cnt_q <= cnt_q + CNT_W'(1);
      else if (!hs && dec)
        cnt_q <= cnt_q - CNT_W'(1);
      if (rsp_done_i && (cnt_q == '0))
        err_q <= 1'b1;
    end
  end

endmodule
